rab_slice_lookup_pipe: RTL and testbench
========================================

// Module: rab_slice_lookup_pipe
// PURPOSE
//  Pipelined, handshaked RAB slice lookup. Compares a virtual address range against N_SLICES
//  configured slices, picks the lowest-index hit and returns the translated physical address,
//  protection and coherence flags. Sits between AXI address-channel decode and the miss/L2 path
//  in the RAB core, and replaces the purely combinational lookup to close timing at larger N_SLICES.
// PARAMETERS
//  N_SLICES        16  number of slices (1..64)
//  N_REGS          4*N_SLICES  config words; slice i uses words 4i..4i+3
//  ADDR_WIDTH_PHYS 40  physical (output) address width
//  ADDR_WIDTH_VIRT 32  virtual (input) address width, <= ADDR_WIDTH_PHYS
//  ID_WIDTH        4   request tag carried through unchanged
// PORTS
//  Clk_CI          in   1            clock
//  Rst_RI          in   1            reset, asynchronous, active-high
//  cfg_regs_i      in   N_REGS x 64  word 4i: min, 4i+1: max, 4i+2: offset, 4i+3: {coh,wen,ren,en} in [3:0]
//  multi_hit_allow_i in 1            1: multiple hits are legal
//  flush_i         in   1            drop all in-flight lookups
//  clr_sticky_i    in   1            clear multi_hit_sticky_o
//  in_valid_i      in   1            request valid
//  in_ready_o      out  1            request accepted when valid & ready
//  in_rw_i         in   1            0 read, 1 write
//  in_addr_min_i   in   ADDR_WIDTH_VIRT  first byte of burst
//  in_addr_max_i   in   ADDR_WIDTH_VIRT  last byte of burst
//  in_id_i         in   ID_WIDTH     tag
//  out_valid_o     out  1            result valid; held until out_ready_i
//  out_ready_i     in   1            result consumer ready
//  out_hit_o       out  1            at least one slice hit
//  out_idx_o       out  $clog2(N_SLICES) lowest hit index (0 on miss)
//  out_prot_o      out  1            selected slice denies rw type
//  out_multi_o     out  1            >1 hit and !multi_hit_allow_i (sampled at compare)
//  out_coherent_o  out  1            coh bit of selected slice
//  out_addr_o      out  ADDR_WIDTH_PHYS translated address (0 on miss)
//  out_id_o        out  ID_WIDTH     tag of this result
//  multi_hit_sticky_o out 1          set by any emitted out_multi_o
// BEHAVIOUR
//  - Reset: all out_* and multi_hit_sticky_o = 0, both stage valids = 0; in_ready_o = 1 after reset.
//  - Stage S1 registers request; S1->S2 per-slice compare in that cycle, S2 registers hit vector,
//    lowest index, prot, coh, offset-adjusted addr. Latency 2 cycles accept->out_valid_o; throughput 1/cycle.
//  - Hit i: en & addr_min>=min & addr_max<=max (unsigned). Prot i: hit & (rw ? !wen : !ren).
//  - out_addr = {zero-ext addr_min} - {zero-ext min} + offset[ADDR_WIDTH_PHYS-1:0], modulo 2^ADDR_WIDTH_PHYS.
//  - Config sampled in the S1 compare cycle; changes after that do not affect the held result.
//  - Backpressure: S2 holds while out_valid_o & !out_ready_i; S1 advances iff S2 empty or draining;
//    in_ready_o = !s1_valid | s1_advance | flush-free combinational (no bubble when full and draining).
//  - flush_i: clears both stage valids next edge; in_ready_o = 0 that cycle; request not accepted.
//  - clr_sticky_i and a new out_multi handshake in same cycle: set wins.
//  - Miss: out_hit_o=0, out_prot_o=0, out_addr_o=0, out_idx_o=0, out_coherent_o=0.
// CONFIGURATION
//  `RAB_LOOKUP_STATS_EN defined: adds outputs stat_hit_o, stat_miss_o, stat_multi_o (32 b each),
//  saturating counters incremented on each out handshake, cleared by clr_sticky_i (increment wins
//  is NOT used: clear wins). Undefined: ports absent, no counter logic.
// STRUCTURE
//  rab_lookup_pkg: slice_cfg_t struct {min,max,offset,coh,wen,ren,en}, CFG_* word index constants,
//  cfg unpack function. Sub-module rab_slice_match: one slice compare -> hit, prot, translated addr;
//  generated N_SLICES times; priority select + pipeline regs in top.
// TESTING
//  1 Slice 0 [0x1000,0x1FFF] off 0x80_0000_0000 en/ren; read 0x1100..0x113F -> 2 cyc later hit=1, idx=0, addr=0x80_0000_0100.
//  2 Slices 2,5 both cover 0x4000, allow=0 -> idx=2, multi=1, sticky=1; allow=1 -> multi=0.
//  3 Write to slice with wen=0 -> hit=1, prot=1; burst 0x1FF0..0x2010 crossing max -> hit=0, addr=0.
//  4 Back-to-back 8 requests, out_ready low 3 cycles mid-stream -> no loss, ids in order, in_ready drops only when both stages full.
//  5 flush_i with 2 in flight -> no out_valid_o for them; next request completes normally.
//  6 Rst_RI asserted mid-stream -> outputs 0 immediately; STATS_EN: 3 hits,1 miss -> stat_hit=3, stat_miss=1.

Source files
------------

// File: rtl/rab_lookup_pkg.sv
// Slice configuration layout shared by the RAB lookup pipeline.
// Each slice owns four 64-bit config words: min, max, offset, flags.
package rab_lookup_pkg;

    localparam int CFG_MIN   = 0;
    localparam int CFG_MAX   = 1;
    localparam int CFG_OFF   = 2;
    localparam int CFG_FLAGS = 3;
    localparam int CFG_WORDS = 4;

    typedef struct packed {
        logic [63:0] min;
        logic [63:0] max;
        logic [63:0] offset;
        logic        coh;
        logic        wen;
        logic        ren;
        logic        en;
    } slice_cfg_t;

    function automatic slice_cfg_t cfg_unpack(
        input logic [63:0] w_min,
        input logic [63:0] w_max,
        input logic [63:0] w_off,
        input logic [63:0] w_flags
    );
        slice_cfg_t c;
        logic       unused_flag_bits;
        c.min            = w_min;
        c.max            = w_max;
        c.offset         = w_off;
        c.coh            = w_flags[3];
        c.wen            = w_flags[2];
        c.ren            = w_flags[1];
        c.en             = w_flags[0];
        unused_flag_bits = ^w_flags[63:4];
        return c;
    endfunction

endpackage

// File: rtl/rab_slice_match.sv
// Single-slice compare: range hit, access protection and translated address.
module rab_slice_match
    import rab_lookup_pkg::*;
#(
    parameter int ADDR_WIDTH_PHYS = 40,
    parameter int ADDR_WIDTH_VIRT = 32
) (
    input  slice_cfg_t                 cfg,
    input  logic                       rw,
    input  logic [ADDR_WIDTH_VIRT-1:0] addr_min,
    input  logic [ADDR_WIDTH_VIRT-1:0] addr_max,
    output logic                       hit,
    output logic                       prot,
    output logic [ADDR_WIDTH_PHYS-1:0] addr
);

    logic [63:0] lo;
    logic [63:0] hi;
    logic        unused_cfg;

    assign lo = 64'(addr_min);
    assign hi = 64'(addr_max);

    assign hit  = cfg.en && (lo >= cfg.min) && (hi <= cfg.max);
    assign prot = hit && (rw ? !cfg.wen : !cfg.ren);

    // Modular arithmetic: truncating operands first gives the same low bits.
    assign addr = ADDR_WIDTH_PHYS'(addr_min)
                - cfg.min[ADDR_WIDTH_PHYS-1:0]
                + cfg.offset[ADDR_WIDTH_PHYS-1:0];

    assign unused_cfg = ^{cfg.offset, cfg.coh};

endmodule

// File: rtl/rab_slice_lookup_pipe.sv
// Two-stage handshaked RAB slice lookup with lowest-index priority select.
// Optional RAB_LOOKUP_STATS_EN adds saturating hit/miss/multi counters.
module rab_slice_lookup_pipe
    import rab_lookup_pkg::*;
#(
    parameter int N_SLICES        = 16,
    parameter int N_REGS          = 4 * N_SLICES,
    parameter int ADDR_WIDTH_PHYS = 40,
    parameter int ADDR_WIDTH_VIRT = 32,
    parameter int ID_WIDTH        = 4,
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic [63:0]                cfg_regs_i [N_REGS],
    input  logic                       multi_hit_allow_i,
    input  logic                       flush_i,
    input  logic                       clr_sticky_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_rw_i,
    input  logic [ADDR_WIDTH_VIRT-1:0] in_addr_min_i,
    input  logic [ADDR_WIDTH_VIRT-1:0] in_addr_max_i,
    input  logic [ID_WIDTH-1:0]        in_id_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_hit_o,
    output logic [IDX_W-1:0]           out_idx_o,
    output logic                       out_prot_o,
    output logic                       out_multi_o,
    output logic                       out_coherent_o,
    output logic [ADDR_WIDTH_PHYS-1:0] out_addr_o,
    output logic [ID_WIDTH-1:0]        out_id_o,
    output logic                       multi_hit_sticky_o
`ifdef RAB_LOOKUP_STATS_EN
    ,
    output logic [31:0]                stat_hit_o,
    output logic [31:0]                stat_miss_o,
    output logic [31:0]                stat_multi_o
`endif
);

    logic                       s1_valid;
    logic                       s1_rw;
    logic [ADDR_WIDTH_VIRT-1:0] s1_min;
    logic [ADDR_WIDTH_VIRT-1:0] s1_max;
    logic [ID_WIDTH-1:0]        s1_id;

    logic s2_free;
    logic s1_advance;
    logic in_fire;
    logic out_fire;

    assign s2_free    = !out_valid_o || out_ready_i;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready_o = !flush_i && (!s1_valid || s2_free);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            s1_valid <= 1'b0;
            s1_rw    <= 1'b0;
            s1_min   <= '0;
            s1_max   <= '0;
            s1_id    <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_rw    <= in_rw_i;
            s1_min   <= in_addr_min_i;
            s1_max   <= in_addr_max_i;
            s1_id    <= in_id_i;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    slice_cfg_t                 cfg   [N_SLICES];
    logic [N_SLICES-1:0]        hits;
    logic [N_SLICES-1:0]        prots;
    logic [ADDR_WIDTH_PHYS-1:0] taddr [N_SLICES];

    for (genvar g = 0; g < N_SLICES; g++) begin : g_slice
        assign cfg[g] = cfg_unpack(
            cfg_regs_i[CFG_WORDS*g + CFG_MIN],
            cfg_regs_i[CFG_WORDS*g + CFG_MAX],
            cfg_regs_i[CFG_WORDS*g + CFG_OFF],
            cfg_regs_i[CFG_WORDS*g + CFG_FLAGS]
        );

        rab_slice_match #(
            .ADDR_WIDTH_PHYS(ADDR_WIDTH_PHYS),
            .ADDR_WIDTH_VIRT(ADDR_WIDTH_VIRT)
        ) u_match (
            .cfg     (cfg[g]),
            .rw      (s1_rw),
            .addr_min(s1_min),
            .addr_max(s1_max),
            .hit     (hits[g]),
            .prot    (prots[g]),
            .addr    (taddr[g])
        );
    end

    logic                       sel_hit;
    logic [IDX_W-1:0]           sel_idx;
    logic                       sel_prot;
    logic                       sel_coh;
    logic [ADDR_WIDTH_PHYS-1:0] sel_addr;
    logic                       sel_multi;

    // Walk high to low so the lowest hitting index is the one left standing.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = '0;
        sel_prot = 1'b0;
        sel_coh  = 1'b0;
        sel_addr = '0;
        for (int i = N_SLICES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                sel_hit  = 1'b1;
                sel_idx  = IDX_W'(i);
                sel_prot = prots[i];
                sel_coh  = cfg[i].coh;
                sel_addr = taddr[i];
            end
        end
    end

    assign sel_multi = (|(hits & (hits - N_SLICES'(1))))
                    && !multi_hit_allow_i;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            out_valid_o    <= 1'b0;
            out_hit_o      <= 1'b0;
            out_idx_o      <= '0;
            out_prot_o     <= 1'b0;
            out_multi_o    <= 1'b0;
            out_coherent_o <= 1'b0;
            out_addr_o     <= '0;
            out_id_o       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (s1_advance) begin
            out_valid_o    <= 1'b1;
            out_hit_o      <= sel_hit;
            out_idx_o      <= sel_idx;
            out_prot_o     <= sel_prot;
            out_multi_o    <= sel_multi;
            out_coherent_o <= sel_coh;
            out_addr_o     <= sel_addr;
            out_id_o       <= s1_id;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            multi_hit_sticky_o <= 1'b0;
        end else if (out_fire && out_multi_o) begin
            multi_hit_sticky_o <= 1'b1;
        end else if (clr_sticky_i) begin
            multi_hit_sticky_o <= 1'b0;
        end
    end

`ifdef RAB_LOOKUP_STATS_EN
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            stat_hit_o   <= '0;
            stat_miss_o  <= '0;
            stat_multi_o <= '0;
        end else if (clr_sticky_i) begin
            stat_hit_o   <= '0;
            stat_miss_o  <= '0;
            stat_multi_o <= '0;
        end else if (out_fire) begin
            if (out_hit_o && stat_hit_o != '1)
                stat_hit_o <= stat_hit_o + 32'd1;
            if (!out_hit_o && stat_miss_o != '1)
                stat_miss_o <= stat_miss_o + 32'd1;
            if (out_multi_o && stat_multi_o != '1)
                stat_multi_o <= stat_multi_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rab_slice_lookup_pipe.sv
// Randomized bench for rab_slice_lookup_pipe against a queue-based reference model.
module tb_rab_slice_lookup_pipe;

    localparam int NS = 16;
    localparam int NR = 4 * NS;
    localparam int PW = 40;
    localparam int VW = 32;
    localparam int IW = 4;
    localparam int XW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0]   cfg [NR];
    logic          allow = 0, flush = 0, clr = 0;
    logic          in_valid = 0, in_ready, rw = 0;
    logic [VW-1:0] amin = 0, amax = 0;
    logic [IW-1:0] id = 0;
    logic          out_valid, out_ready = 1;
    logic          hit, prot, multi, coh, sticky;
    logic [XW-1:0] idx;
    logic [PW-1:0] addr;
    logic [IW-1:0] oid;
`ifdef RAB_LOOKUP_STATS_EN
    logic [31:0]   st_hit, st_miss, st_multi;
`endif

    rab_slice_lookup_pipe dut (
        .Clk_CI            (clk),
        .Rst_RI            (rst),
        .cfg_regs_i        (cfg),
        .multi_hit_allow_i (allow),
        .flush_i           (flush),
        .clr_sticky_i      (clr),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_rw_i           (rw),
        .in_addr_min_i     (amin),
        .in_addr_max_i     (amax),
        .in_id_i           (id),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_hit_o         (hit),
        .out_idx_o         (idx),
        .out_prot_o        (prot),
        .out_multi_o       (multi),
        .out_coherent_o    (coh),
        .out_addr_o        (addr),
        .out_id_o          (oid),
        .multi_hit_sticky_o(sticky)
`ifdef RAB_LOOKUP_STATS_EN
        ,
        .stat_hit_o        (st_hit),
        .stat_miss_o       (st_miss),
        .stat_multi_o      (st_multi)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          hit, prot, multi, coh;
        int            idx;
        logic [PW-1:0] addr;
        logic [IW-1:0] id;
    } exp_t;

    exp_t q[$];
    logic exp_sticky = 0;

    // Reference: scan all slices, keep the lowest-index hit, count hits.
    function automatic exp_t model(logic w, logic [VW-1:0] lo, logic [VW-1:0] hi,
                                   logic [IW-1:0] t, logic al);
        exp_t e;
        int   n;
        e = '{default: 0};
        e.id = t;
        n = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            logic [63:0] mn, mx, of;
            logic [3:0]  f;
            mn = cfg[4*i];
            mx = cfg[4*i+1];
            of = cfg[4*i+2];
            f  = cfg[4*i+3][3:0];
            if (f[0] && {32'b0, lo} >= mn && {32'b0, hi} <= mx) begin
                n++;
                e.hit  = 1;
                e.idx  = i;
                e.coh  = f[3];
                e.prot = w ? !f[2] : !f[1];
                e.addr = PW'({32'b0, lo} - mn + of);
            end
        end
        e.multi = (n > 1) && !al;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        if (rst) begin
            q.delete();
            exp_sticky = 0;
        end else begin
            check("in_ready", in_ready, !flush && (q.size() < 2 || out_ready));
            check("sticky", sticky, exp_sticky);
            hs = out_valid && out_ready;
            if (q.size() == 0) begin
                check("valid_empty_q", out_valid, 0);
                if (clr) exp_sticky = 0;
            end else if (hs) begin
                e = q.pop_front();
                check("id", oid, e.id);
                check("hit", hit, e.hit);
                check("idx", idx, e.idx);
                check("prot", prot, e.prot);
                check("multi", multi, e.multi);
                check("coh", coh, e.coh);
                check("addr", addr, e.addr);
                if (e.multi) exp_sticky = 1;
                else if (clr) exp_sticky = 0;
            end else if (clr) begin
                exp_sticky = 0;
            end
            if (flush) q.delete();
            if (in_valid && in_ready) q.push_back(model(rw, amin, amax, id, allow));
        end
    end

    task automatic set_slice(int i, logic [63:0] mn, logic [63:0] mx,
                             logic [63:0] of, logic [63:0] fl);
        cfg[4*i]   = mn;
        cfg[4*i+1] = mx;
        cfg[4*i+2] = of;
        cfg[4*i+3] = fl;
    endtask

    task automatic rand_cfg();
        for (int i = 0; i < NS; i++) begin
            logic [63:0] mn;
            mn = 64'($urandom_range(0, 'h7000)) & ~64'hFF;
            set_slice(i, mn, mn + 64'($urandom_range('h100, 'h1800)),
                      {$urandom, $urandom},
                      {$urandom, $urandom[31:4], 2'($urandom), 1'($urandom),
                       1'($urandom_range(0, 3) != 0)});
        end
    endtask

    task automatic one(input logic w, input logic [31:0] lo, input logic [31:0] hi,
                       input logic [3:0] t, output int lat);
        int k;
        k = 0;
        @(posedge clk); #1;
        rw = w; amin = lo; amax = hi; id = t; in_valid = 1;
        do begin @(negedge clk); k++; end while (!in_ready && k < 20);
        if (k >= 20) check("accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    endtask

    task automatic new_req(int n);
        logic [31:0] b;
        b = $urandom_range(0, 'h7FFF);
        rw = 1'($urandom);
        amin = b;
        amax = ($urandom_range(0, 7) == 0) ? b + $urandom_range(0, 'h2000)
                                            : b + $urandom_range(0, 'h3F);
        id = n[3:0];
    endtask

    task automatic stream(int n, bit rnd, int stall_at);
        int sent, cyc;
        bit hs;
        sent = 0;
        cyc = 0;
        @(posedge clk); #1;
        new_req(0);
        in_valid = 1;
        while (sent < n && cyc < 20 * n) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                sent++;
                if (sent < n) new_req(sent);
                else in_valid = 0;
            end
            if (rnd) begin
                out_ready = ($urandom_range(0, 9) < 7);
                flush = ($urandom_range(0, 39) == 0);
                clr = ($urandom_range(0, 15) == 0);
            end else begin
                out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
            end
        end
        check("stream_sent", sent, n);
        in_valid = 0; flush = 0; clr = 0; out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        for (int i = 0; i < NR; i++) cfg[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_addr", addr, 0);
        check("rst_sticky", sticky, 0);

        // Single-slice translation and latency.
        set_slice(0, 64'h1000, 64'h1FFF, 64'h80_0000_0000, 64'h3);
        one(0, 'h1100, 'h113F, 4'h1, lat);
        check("t1_lat", lat, 2);
        check("t1_hit", hit, 1);
        check("t1_idx", idx, 0);
        check("t1_addr", addr, 64'h80_0000_0100);

        // Overlapping slices: lowest index wins, multi only when not allowed.
        set_slice(2, 64'h4000, 64'h4FFF, 64'h0, 64'hB);
        set_slice(5, 64'h4000, 64'h4FFF, 64'h10000, 64'h3);
        allow = 0;
        one(0, 'h4000, 'h4003, 4'h2, lat);
        check("t2_idx", idx, 2);
        check("t2_multi", multi, 1);
        check("t2_coh", coh, 1);
        check("t2_addr", addr, 64'h0);
        @(posedge clk); #1;
        check("t2_sticky", sticky, 1);
        allow = 1;
        one(0, 'h4010, 'h4020, 4'h3, lat);
        check("t2_allow_multi", multi, 0);
        check("t2_allow_idx", idx, 2);
        @(posedge clk); #1;
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        check("t2_clr", sticky, 0);

        // Write denied, and a burst running past max.
        one(1, 'h1200, 'h120F, 4'h4, lat);
        check("t3_hit", hit, 1);
        check("t3_prot", prot, 1);
        one(0, 'h1FF0, 'h2010, 4'h5, lat);
        check("t3_miss_hit", hit, 0);
        check("t3_miss_addr", addr, 0);
        check("t3_miss_prot", prot, 0);

        // Back-to-back stream with a three-cycle stall.
        stream(8, 0, 3);

        // Flush with two lookups in flight.
        @(posedge clk); #1;
        out_ready = 0;
        rw = 0; amin = 'h1100; amax = 'h1100; id = 4'h6; in_valid = 1;
        @(posedge clk); #1;
        id = 4'h7;
        @(posedge clk); #1;
        in_valid = 0;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        out_ready = 1;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_valid", out_valid, 0);
        end
        one(0, 'h1180, 'h1180, 4'h8, lat);
        check("t5_after_id", oid, 8);
        check("t5_after_addr", addr, 64'h80_0000_0180);

        // Held result ignores later config edits; async reset clears it.
        allow = 0;
        one(0, 'h4000, 'h4000, 4'h9, lat);
        @(posedge clk); #1;
        out_ready = 0;
        one(0, 'h1100, 'h1100, 4'hA, lat);
        @(posedge clk); #1;
        cfg[2] = 64'h0;
        @(negedge clk);
        check("t6_cfg_hold", addr, 64'h80_0000_0100);
        check("t6_sticky_before", sticky, 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_hit", hit, 0);
        check("t6_rst_addr", addr, 0);
        check("t6_rst_id", oid, 0);
        check("t6_rst_sticky", sticky, 0);
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        allow = 1;
        cfg[2] = 64'h80_0000_0000;
        for (int i = 0; i < 3; i++) one(0, 'h1100, 'h1100, 4'(i), lat);
        one(0, 'h9000, 'h9000, 4'h3, lat);
        @(posedge clk); #1;
`ifdef RAB_LOOKUP_STATS_EN
        check("stat_hit", st_hit, 3);
        check("stat_miss", st_miss, 1);
        check("stat_multi", st_multi, 0);
`endif

        // Randomized rounds with backpressure, flushes and sticky clears.
        for (int r = 0; r < 6; r++) begin
            rand_cfg();
            allow = 1'($urandom);
            stream(200, 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
